// File: rtl/turn_scheduler.sv
// Turn sequencer for the Cat vs Dog duel: grants turns, tracks flight, applies damage, declares winner.
// Latency: every output is registered; state, HP and enables update on the edge after the qualifying input pulse.
// Backpressure: none; input pulses arriving in a state that does not expect them are dropped.
//
// Ports:
//   clk, rst                       clock and asynchronous active-high reset
//   game_start                     pulse, (re)starts a game from IDLE or GAME_OVER
//   dog_turn_done, cat_turn_done   pulses from the per-player turn FSMs
//   projectile_landed              pulse from the projectile engine, qualified by hit_dog / hit_cat
//   dog_turn, cat_turn             enables for the per-player turn FSMs
//   in_flight                      projectile in the air
//   timeout_pulse                  one-cycle pulse when a TURN or FLIGHT overruns
//   dog_hp, cat_hp                 hit points
//   turn_count                     completed turns, wraps at 8 bits
//   game_over, winner              end-of-game flag and result (0 none, 1 dog, 2 cat, 3 draw)
module turn_scheduler #(
    parameter int unsigned TURN_TIMEOUT  = 650_000_000,
    parameter int unsigned SETTLE_CYCLES = 65_000_000,
    parameter int unsigned HP_INIT       = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       game_start,
    input  logic       dog_turn_done,
    input  logic       cat_turn_done,
    input  logic       projectile_landed,
    input  logic       hit_dog,
    input  logic       hit_cat,
    output logic       dog_turn,
    output logic       cat_turn,
    output logic       in_flight,
    output logic       timeout_pulse,
    output logic [3:0] dog_hp,
    output logic [3:0] cat_hp,
    output logic [7:0] turn_count,
    output logic       game_over,
    output logic [1:0] winner
);

    localparam logic [31:0] TURN_LAST   = 32'(TURN_TIMEOUT - 1);
    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
    localparam logic [3:0]  HP_START    = 4'(HP_INIT);

    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_DOG  = 2'd1;
    localparam logic [1:0] WIN_CAT  = 2'd2;
    localparam logic [1:0] WIN_DRAW = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_DOG_TURN   = 3'd1,
        S_DOG_FLIGHT = 3'd2,
        S_CAT_TURN   = 3'd3,
        S_CAT_FLIGHT = 3'd4,
        S_SETTLE     = 3'd5,
        S_GAME_OVER  = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [3:0]  dog_hp_q, dog_hp_d;
    logic [3:0]  cat_hp_q, cat_hp_d;
    logic [7:0]  turn_cnt_q, turn_cnt_d;
    logic [1:0]  winner_q, winner_d;
    // Which side gets the next grant out of SETTLE; flipped whenever a turn is granted.
    logic        next_is_cat_q, next_is_cat_d;
    logic        dog_turn_q, dog_turn_d;
    logic        cat_turn_q, cat_turn_d;
    logic        in_flight_q, in_flight_d;
    logic        timeout_q, timeout_d;
    logic        game_over_q, game_over_d;

    // Damage is applied per side independently; a side already at 0 stays at 0.
    logic [3:0] dog_hp_hit, cat_hp_hit;
    assign dog_hp_hit = (hit_dog && (dog_hp_q != 4'd0)) ? dog_hp_q - 4'd1 : dog_hp_q;
    assign cat_hp_hit = (hit_cat && (cat_hp_q != 4'd0)) ? cat_hp_q - 4'd1 : cat_hp_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        dog_hp_d      = dog_hp_q;
        cat_hp_d      = cat_hp_q;
        turn_cnt_d    = turn_cnt_q;
        winner_d      = winner_q;
        next_is_cat_d = next_is_cat_q;
        timeout_d     = 1'b0;

        unique case (state_q)
            S_IDLE, S_GAME_OVER: begin
                if (game_start) begin
                    state_d       = S_DOG_TURN;
                    cnt_d         = 32'd0;
                    dog_hp_d      = HP_START;
                    cat_hp_d      = HP_START;
                    turn_cnt_d    = 8'd0;
                    winner_d      = WIN_NONE;
                    next_is_cat_d = 1'b1;
                end
            end

            S_DOG_TURN, S_CAT_TURN: begin
                // Only the active side's done pulse counts; it wins over a same-cycle timeout.
                if ((state_q == S_DOG_TURN) ? dog_turn_done : cat_turn_done) begin
                    state_d = (state_q == S_DOG_TURN) ? S_DOG_FLIGHT : S_CAT_FLIGHT;
                    cnt_d   = 32'd0;
                end else if (cnt_q == TURN_LAST) begin
                    state_d   = S_SETTLE;
                    cnt_d     = 32'd0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            S_DOG_FLIGHT, S_CAT_FLIGHT: begin
                if (projectile_landed) begin
                    state_d  = S_SETTLE;
                    cnt_d    = 32'd0;
                    dog_hp_d = dog_hp_hit;
                    cat_hp_d = cat_hp_hit;
                end else if (cnt_q == TURN_LAST) begin
                    // A lost projectile is scored as a miss.
                    state_d   = S_SETTLE;
                    cnt_d     = 32'd0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d      = 32'd0;
                    turn_cnt_d = turn_cnt_q + 8'd1;
                    if ((dog_hp_q == 4'd0) || (cat_hp_q == 4'd0)) begin
                        state_d = S_GAME_OVER;
                        if ((dog_hp_q == 4'd0) && (cat_hp_q == 4'd0)) begin
                            winner_d = WIN_DRAW;
                        end else if (cat_hp_q == 4'd0) begin
                            winner_d = WIN_DOG;
                        end else begin
                            winner_d = WIN_CAT;
                        end
                    end else begin
                        state_d       = next_is_cat_q ? S_CAT_TURN : S_DOG_TURN;
                        next_is_cat_d = ~next_is_cat_q;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = 32'd0;
            end
        endcase

        // Enables follow the next state so they are registered alongside it,
        // which drops x_turn on the edge that consumes x_turn_done.
        dog_turn_d  = (state_d == S_DOG_TURN);
        cat_turn_d  = (state_d == S_CAT_TURN);
        in_flight_d = (state_d == S_DOG_FLIGHT) || (state_d == S_CAT_FLIGHT);
        game_over_d = (state_d == S_GAME_OVER);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= 32'd0;
            dog_hp_q      <= HP_START;
            cat_hp_q      <= HP_START;
            turn_cnt_q    <= 8'd0;
            winner_q      <= WIN_NONE;
            next_is_cat_q <= 1'b0;
            dog_turn_q    <= 1'b0;
            cat_turn_q    <= 1'b0;
            in_flight_q   <= 1'b0;
            timeout_q     <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            dog_hp_q      <= dog_hp_d;
            cat_hp_q      <= cat_hp_d;
            turn_cnt_q    <= turn_cnt_d;
            winner_q      <= winner_d;
            next_is_cat_q <= next_is_cat_d;
            dog_turn_q    <= dog_turn_d;
            cat_turn_q    <= cat_turn_d;
            in_flight_q   <= in_flight_d;
            timeout_q     <= timeout_d;
            game_over_q   <= game_over_d;
        end
    end

    assign dog_turn      = dog_turn_q;
    assign cat_turn      = cat_turn_q;
    assign in_flight     = in_flight_q;
    assign timeout_pulse = timeout_q;
    assign dog_hp        = dog_hp_q;
    assign cat_hp        = cat_hp_q;
    assign turn_count    = turn_cnt_q;
    assign game_over     = game_over_q;
    assign winner        = winner_q;

endmodule

// File: tb/tb_turn_scheduler.sv
module tb_turn_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       game_start = 1'b0;
    logic       dog_turn_done = 1'b0;
    logic       cat_turn_done = 1'b0;
    logic       projectile_landed = 1'b0;
    logic       hit_dog = 1'b0;
    logic       hit_cat = 1'b0;
    logic       dog_turn, cat_turn, in_flight, timeout_pulse, game_over;
    logic [3:0] dog_hp, cat_hp;
    logic [7:0] turn_count;
    logic [1:0] winner;

    int total = 0;
    int bad   = 0;

    turn_scheduler #(
        .TURN_TIMEOUT (20),
        .SETTLE_CYCLES(4),
        .HP_INIT      (2)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .game_start       (game_start),
        .dog_turn_done    (dog_turn_done),
        .cat_turn_done    (cat_turn_done),
        .projectile_landed(projectile_landed),
        .hit_dog          (hit_dog),
        .hit_cat          (hit_cat),
        .dog_turn         (dog_turn),
        .cat_turn         (cat_turn),
        .in_flight        (in_flight),
        .timeout_pulse    (timeout_pulse),
        .dog_hp           (dog_hp),
        .cat_hp           (cat_hp),
        .turn_count       (turn_count),
        .game_over        (game_over),
        .winner           (winner)
    );

    always #5 clk = ~clk;

    // Advance n clock edges; outputs are then sampled 1 time unit after the edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        game_start = 1'b0; dog_turn_done = 1'b0; cat_turn_done = 1'b0;
        projectile_landed = 1'b0; hit_dog = 1'b0; hit_cat = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic start_game();
        game_start = 1'b1; tick(1); game_start = 1'b0;
    endtask

    task automatic dog_done();
        dog_turn_done = 1'b1; tick(1); dog_turn_done = 1'b0;
    endtask

    task automatic cat_done();
        cat_turn_done = 1'b1; tick(1); cat_turn_done = 1'b0;
    endtask

    task automatic land(input logic hd, input logic hc);
        projectile_landed = 1'b1; hit_dog = hd; hit_cat = hc;
        tick(1);
        projectile_landed = 1'b0; hit_dog = 1'b0; hit_cat = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total += 9;
        if (dog_turn !== 1'b0)      begin bad++; $display("FAIL reset_dog_turn got=%0b want=0", dog_turn); end
        if (cat_turn !== 1'b0)      begin bad++; $display("FAIL reset_cat_turn got=%0b want=0", cat_turn); end
        if (in_flight !== 1'b0)     begin bad++; $display("FAIL reset_in_flight got=%0b want=0", in_flight); end
        if (timeout_pulse !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%0b want=0", timeout_pulse); end
        if (dog_hp !== 4'd2)        begin bad++; $display("FAIL reset_dog_hp got=%0d want=2", dog_hp); end
        if (cat_hp !== 4'd2)        begin bad++; $display("FAIL reset_cat_hp got=%0d want=2", cat_hp); end
        if (turn_count !== 8'd0)    begin bad++; $display("FAIL reset_turn_count got=%0d want=0", turn_count); end
        if (game_over !== 1'b0)     begin bad++; $display("FAIL reset_game_over got=%0b want=0", game_over); end
        if (winner !== 2'd0)        begin bad++; $display("FAIL reset_winner got=%0d want=0", winner); end
    endtask

    task automatic test_basic_turn();
        do_reset();
        start_game();
        total++; if (dog_turn !== 1'b1) begin bad++; $display("FAIL t1_dog_turn got=%0b want=1", dog_turn); end
        tick(3);
        dog_done();
        total++; if (in_flight !== 1'b1) begin bad++; $display("FAIL t1_in_flight got=%0b want=1", in_flight); end
        total++; if (dog_turn !== 1'b0)  begin bad++; $display("FAIL t1_dog_turn_drop got=%0b want=0", dog_turn); end
        land(1'b0, 1'b1);
        total++; if (cat_hp !== 4'd1)    begin bad++; $display("FAIL t1_cat_hp got=%0d want=1", cat_hp); end
        total++; if (dog_hp !== 4'd2)    begin bad++; $display("FAIL t1_dog_hp got=%0d want=2", dog_hp); end
        total++; if (in_flight !== 1'b0) begin bad++; $display("FAIL t1_flight_end got=%0b want=0", in_flight); end
        tick(3);
        total++; if (cat_turn !== 1'b0)  begin bad++; $display("FAIL t1_settle_early got=%0b want=0", cat_turn); end
        tick(1);
        total++; if (cat_turn !== 1'b1)  begin bad++; $display("FAIL t1_cat_turn got=%0b want=1", cat_turn); end
        total++; if (turn_count !== 8'd1) begin bad++; $display("FAIL t1_turn_count got=%0d want=1", turn_count); end
    endtask

    task automatic test_turn_timeout();
        do_reset();
        start_game();
        tick(19);
        total++; if (dog_turn !== 1'b1)      begin bad++; $display("FAIL t2_dog_turn_held got=%0b want=1", dog_turn); end
        total++; if (timeout_pulse !== 1'b0) begin bad++; $display("FAIL t2_timeout_early got=%0b want=0", timeout_pulse); end
        tick(1);
        total++; if (timeout_pulse !== 1'b1) begin bad++; $display("FAIL t2_timeout got=%0b want=1", timeout_pulse); end
        total++; if (dog_turn !== 1'b0)      begin bad++; $display("FAIL t2_dog_turn_drop got=%0b want=0", dog_turn); end
        tick(1);
        total++; if (timeout_pulse !== 1'b0) begin bad++; $display("FAIL t2_timeout_once got=%0b want=0", timeout_pulse); end
        tick(2);
        total++; if (cat_turn !== 1'b0)      begin bad++; $display("FAIL t2_settle_early got=%0b want=0", cat_turn); end
        tick(1);
        total++; if (cat_turn !== 1'b1)      begin bad++; $display("FAIL t2_cat_turn got=%0b want=1", cat_turn); end
        total++; if (dog_hp !== 4'd2 || cat_hp !== 4'd2) begin bad++; $display("FAIL t2_hp got=%0d/%0d want=2/2", dog_hp, cat_hp); end
        total++; if (turn_count !== 8'd1)    begin bad++; $display("FAIL t2_turn_count got=%0d want=1", turn_count); end
    endtask

    task automatic test_done_vs_timeout();
        do_reset();
        start_game();
        tick(19);
        dog_done();
        total++; if (in_flight !== 1'b1)     begin bad++; $display("FAIL t3_in_flight got=%0b want=1", in_flight); end
        total++; if (timeout_pulse !== 1'b0) begin bad++; $display("FAIL t3_no_timeout got=%0b want=0", timeout_pulse); end
        tick(19);
        total++; if (in_flight !== 1'b1)     begin bad++; $display("FAIL t3_flight_held got=%0b want=1", in_flight); end
        tick(1);
        total++; if (timeout_pulse !== 1'b1) begin bad++; $display("FAIL t3_flight_timeout got=%0b want=1", timeout_pulse); end
        total++; if (in_flight !== 1'b0)     begin bad++; $display("FAIL t3_flight_drop got=%0b want=0", in_flight); end
        total++; if (dog_hp !== 4'd2 || cat_hp !== 4'd2) begin bad++; $display("FAIL t3_hp got=%0d/%0d want=2/2", dog_hp, cat_hp); end
    endtask

    task automatic test_dog_wins();
        do_reset();
        start_game();
        cat_done();
        total++; if (dog_turn !== 1'b1 || in_flight !== 1'b0) begin bad++; $display("FAIL t4_stray_cat_done dog_turn=%0b in_flight=%0b want=1/0", dog_turn, in_flight); end
        dog_done();
        land(1'b0, 1'b1);
        tick(4);
        total++; if (cat_turn !== 1'b1) begin bad++; $display("FAIL t4_cat_turn got=%0b want=1", cat_turn); end
        land(1'b0, 1'b1);
        total++; if (cat_hp !== 4'd1 || cat_turn !== 1'b1) begin bad++; $display("FAIL t4_stray_land cat_hp=%0d cat_turn=%0b want=1/1", cat_hp, cat_turn); end
        cat_done();
        land(1'b0, 1'b0);
        tick(4);
        total++; if (dog_turn !== 1'b1)   begin bad++; $display("FAIL t4_dog_turn2 got=%0b want=1", dog_turn); end
        total++; if (turn_count !== 8'd2) begin bad++; $display("FAIL t4_turn_count2 got=%0d want=2", turn_count); end
        dog_done();
        land(1'b0, 1'b1);
        total++; if (cat_hp !== 4'd0)     begin bad++; $display("FAIL t4_cat_hp0 got=%0d want=0", cat_hp); end
        tick(3);
        total++; if (game_over !== 1'b0)  begin bad++; $display("FAIL t4_over_early got=%0b want=0", game_over); end
        tick(1);
        total++; if (game_over !== 1'b1)  begin bad++; $display("FAIL t4_game_over got=%0b want=1", game_over); end
        total++; if (winner !== 2'd1)     begin bad++; $display("FAIL t4_winner got=%0d want=1", winner); end
        total++; if (turn_count !== 8'd3) begin bad++; $display("FAIL t4_turn_count3 got=%0d want=3", turn_count); end
        total++; if (dog_turn !== 1'b0 || cat_turn !== 1'b0) begin bad++; $display("FAIL t4_enables_off got=%0b/%0b want=0/0", dog_turn, cat_turn); end
        land(1'b1, 1'b0);
        total++; if (dog_hp !== 4'd2 || winner !== 2'd1) begin bad++; $display("FAIL t4_over_land dog_hp=%0d winner=%0d want=2/1", dog_hp, winner); end
        start_game();
        total++; if (dog_hp !== 4'd2 || cat_hp !== 4'd2) begin bad++; $display("FAIL t4_restart_hp got=%0d/%0d want=2/2", dog_hp, cat_hp); end
        total++; if (dog_turn !== 1'b1)   begin bad++; $display("FAIL t4_restart_dog_turn got=%0b want=1", dog_turn); end
        total++; if (turn_count !== 8'd0) begin bad++; $display("FAIL t4_restart_turn_count got=%0d want=0", turn_count); end
        total++; if (game_over !== 1'b0 || winner !== 2'd0) begin bad++; $display("FAIL t4_restart_over over=%0b winner=%0d want=0/0", game_over, winner); end
    endtask

    task automatic test_draw();
        do_reset();
        start_game();
        dog_done();
        land(1'b1, 1'b1);
        total++; if (dog_hp !== 4'd1 || cat_hp !== 4'd1) begin bad++; $display("FAIL t5_hp11 got=%0d/%0d want=1/1", dog_hp, cat_hp); end
        tick(4);
        cat_done();
        land(1'b1, 1'b1);
        tick(4);
        total++; if (dog_hp !== 4'd0 || cat_hp !== 4'd0) begin bad++; $display("FAIL t5_hp00 got=%0d/%0d want=0/0", dog_hp, cat_hp); end
        total++; if (game_over !== 1'b1) begin bad++; $display("FAIL t5_game_over got=%0b want=1", game_over); end
        total++; if (winner !== 2'd3)    begin bad++; $display("FAIL t5_winner got=%0d want=3", winner); end
    endtask

    task automatic test_reset_in_flight();
        do_reset();
        start_game();
        dog_done();
        land(1'b0, 1'b1);
        tick(4);
        cat_done();
        total++; if (in_flight !== 1'b1) begin bad++; $display("FAIL t6_in_flight got=%0b want=1", in_flight); end
        #3 rst = 1'b1;
        #1;
        total++; if (in_flight !== 1'b0)  begin bad++; $display("FAIL t6_async_in_flight got=%0b want=0", in_flight); end
        total++; if (cat_hp !== 4'd2)     begin bad++; $display("FAIL t6_async_cat_hp got=%0d want=2", cat_hp); end
        total++; if (turn_count !== 8'd0) begin bad++; $display("FAIL t6_async_turn_count got=%0d want=0", turn_count); end
        tick(1);
        rst = 1'b0;
        tick(2);
        total++; if (dog_turn !== 1'b0 || cat_turn !== 1'b0 || in_flight !== 1'b0 || timeout_pulse !== 1'b0 || game_over !== 1'b0)
            begin bad++; $display("FAIL t6_idle outputs=%0b%0b%0b%0b%0b want=00000", dog_turn, cat_turn, in_flight, timeout_pulse, game_over); end
        start_game();
        total++; if (dog_turn !== 1'b1) begin bad++; $display("FAIL t6_idle_start got=%0b want=1", dog_turn); end
    endtask

    initial begin
        test_reset();
        test_basic_turn();
        test_turn_timeout();
        test_done_vs_timeout();
        test_dog_wins();
        test_draw();
        test_reset_in_flight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
